// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - result-source and writeback-port bundle for writeback_arbiter
interface writeback_arbiter_if #(
   parameter int DW = 16,
   parameter int TW = 5
);
   logic          a0_valid;
   logic [DW-1:0] a0_data;
   logic [TW-1:0] a0_tag;
   logic          a1_valid;
   logic [DW-1:0] a1_data;
   logic [TW-1:0] a1_tag;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic [TW-1:0] m_tag;
   logic          ls_valid;
   logic [7:0]    ls_data;
   logic [TW-1:0] ls_tag;
   logic [3:0]    src_ready;
   logic          wb0_en;
   logic [TW-1:0] wb0_tag;
   logic [DW-1:0] wb0_data;
   logic          wb1_en;
   logic [TW-1:0] wb1_tag;
   logic [DW-1:0] wb1_data;
   logic          overflow_err;

   modport master (
      output a0_valid, a0_data, a0_tag, a1_valid, a1_data, a1_tag,
             m_valid, m_data, m_tag, ls_valid, ls_data, ls_tag,
      input  src_ready, wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data,
             overflow_err
   );

   modport slave (
      input  a0_valid, a0_data, a0_tag, a1_valid, a1_data, a1_tag,
             m_valid, m_data, m_tag, ls_valid, ls_data, ls_tag,
      output src_ready, wb0_en, wb0_tag, wb0_data, wb1_en, wb1_tag, wb1_data,
             overflow_err
   );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - per-unit result FIFOs arbitrated round-robin onto two write ports
module writeback_arbiter #(
   parameter int DEPTH = 2,
   parameter int DW    = 16,
   parameter int TW    = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   writeback_arbiter_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DW-1:0] data_mem [4][DEPTH];
   logic [TW-1:0] tag_mem  [4][DEPTH];
   logic [PW-1:0] wr_ptr   [4];
   logic [PW-1:0] rd_ptr   [4];
   logic [CW-1:0] count    [4];
   logic [1:0]    rr_ptr;

   logic [3:0]    in_valid, ready, push, pop, not_empty;
   logic [DW-1:0] in_data   [4];
   logic [TW-1:0] in_tag    [4];
   logic [DW-1:0] head_data [4];
   logic [TW-1:0] head_tag  [4];

   logic          g0_hit, g1_hit;
   logic [1:0]    g0_src, g1_src;

   assign in_valid = {bus.ls_valid, bus.m_valid, bus.a1_valid, bus.a0_valid};

   always_comb begin
      in_data[0] = bus.a0_data;
      in_data[1] = bus.a1_data;
      in_data[2] = bus.m_data;
      in_data[3] = {{(DW-8){1'b0}}, bus.ls_data};
      in_tag[0]  = bus.a0_tag;
      in_tag[1]  = bus.a1_tag;
      in_tag[2]  = bus.m_tag;
      in_tag[3]  = bus.ls_tag;
   end

   // Ready looks only at registered occupancy, so a full FIFO refuses even while popping.
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         ready[i]     = (count[i] != CW'(DEPTH));
         not_empty[i] = (count[i] != '0);
         head_data[i] = data_mem[i][rd_ptr[i]];
         head_tag[i]  = tag_mem[i][rd_ptr[i]];
      end
   end

   assign push          = in_valid & ready;
   assign bus.src_ready = ready;

   // Port 1 skips any head whose tag matches port 0 so both ports never hit one register.
   always_comb begin
      logic [1:0] idx;
      g0_hit = 1'b0;
      g1_hit = 1'b0;
      g0_src = rr_ptr;
      g1_src = rr_ptr;
      pop    = '0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (!g0_hit) begin
            if (not_empty[idx]) begin
               g0_hit = 1'b1;
               g0_src = idx;
            end
         end else if (!g1_hit && not_empty[idx] && (head_tag[idx] != head_tag[g0_src])) begin
            g1_hit = 1'b1;
            g1_src = idx;
         end
      end
      if (g0_hit) pop[g0_src] = 1'b1;
      if (g1_hit) pop[g1_src] = 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (push[i]) begin
            data_mem[i][wr_ptr[i]] <= in_data[i];
            tag_mem[i][wr_ptr[i]]  <= in_tag[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr           <= 2'd0;
         bus.wb0_en       <= 1'b0;
         bus.wb0_tag      <= '0;
         bus.wb0_data     <= '0;
         bus.wb1_en       <= 1'b0;
         bus.wb1_tag      <= '0;
         bus.wb1_data     <= '0;
         bus.overflow_err <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + 1'b1;
               2'b01:   count[i] <= count[i] - 1'b1;
               default: count[i] <= count[i];
            endcase
         end
         bus.wb0_en <= g0_hit;
         if (g0_hit) begin
            bus.wb0_tag  <= head_tag[g0_src];
            bus.wb0_data <= head_data[g0_src];
         end
         bus.wb1_en <= g1_hit;
         if (g1_hit) begin
            bus.wb1_tag  <= head_tag[g1_src];
            bus.wb1_data <= head_data[g1_src];
         end
         if (g1_hit)      rr_ptr <= g1_src + 2'd1;
         else if (g0_hit) rr_ptr <= g0_src + 2'd1;
         if (|(in_valid & ~ready)) bus.overflow_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   writeback_arbiter_if #(.DW(16), .TW(5)) bus ();

   writeback_arbiter #(.DEPTH(2), .DW(16), .TW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.a0_valid = 1'b0; bus.a0_data = '0; bus.a0_tag = '0;
      bus.a1_valid = 1'b0; bus.a1_data = '0; bus.a1_tag = '0;
      bus.m_valid  = 1'b0; bus.m_data  = '0; bus.m_tag  = '0;
      bus.ls_valid = 1'b0; bus.ls_data = '0; bus.ls_tag = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic push_all(input logic [4:0] t0, input logic [15:0] d0,
                           input logic [4:0] t1, input logic [15:0] d1,
                           input logic [4:0] t2, input logic [15:0] d2,
                           input logic [4:0] t3, input logic [7:0]  d3);
      bus.a0_valid = 1'b1; bus.a0_tag = t0; bus.a0_data = d0;
      bus.a1_valid = 1'b1; bus.a1_tag = t1; bus.a1_data = d1;
      bus.m_valid  = 1'b1; bus.m_tag  = t2; bus.m_data  = d2;
      bus.ls_valid = 1'b1; bus.ls_tag = t3; bus.ls_data = d3;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #1;

      // reset held while A0 presents a result
      bus.a0_valid = 1'b1; bus.a0_tag = 5'd5; bus.a0_data = 16'h1234;
      tick();
      tick();
      expect_eq("rst_wb0_en", bus.wb0_en, 0);
      expect_eq("rst_wb1_en", bus.wb1_en, 0);
      expect_eq("rst_src_ready", bus.src_ready, 4'hF);
      expect_eq("rst_overflow", bus.overflow_err, 0);
      expect_eq("rst_wb0_tag", bus.wb0_tag, 0);
      bus.a0_valid = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();
      expect_eq("rst_after_wb0_en", bus.wb0_en, 0);
      expect_eq("rst_after_wb1_en", bus.wb1_en, 0);

      // single A0 result, visible two edges later
      do_reset();
      bus.a0_valid = 1'b1; bus.a0_tag = 5'd3; bus.a0_data = 16'h68AC;
      tick();
      clear_inputs();
      expect_eq("single_c1_wb0_en", bus.wb0_en, 0);
      tick();
      expect_eq("single_wb0_en", bus.wb0_en, 1);
      expect_eq("single_wb0_tag", bus.wb0_tag, 3);
      expect_eq("single_wb0_data", bus.wb0_data, 16'h68AC);
      expect_eq("single_wb1_en", bus.wb1_en, 0);
      tick();
      expect_eq("single_idle_wb0_en", bus.wb0_en, 0);
      expect_eq("single_hold_wb0_data", bus.wb0_data, 16'h68AC);

      // four-way contention from rr_ptr=0
      do_reset();
      push_all(5'd1, 16'h1111, 5'd2, 16'h2222, 5'd3, 16'h3333, 5'd4, 8'hA5);
      tick();
      clear_inputs();
      tick();
      expect_eq("four_c2_wb0_en", bus.wb0_en, 1);
      expect_eq("four_c2_wb0_tag", bus.wb0_tag, 1);
      expect_eq("four_c2_wb0_data", bus.wb0_data, 16'h1111);
      expect_eq("four_c2_wb1_en", bus.wb1_en, 1);
      expect_eq("four_c2_wb1_tag", bus.wb1_tag, 2);
      expect_eq("four_c2_wb1_data", bus.wb1_data, 16'h2222);
      // rr_ptr should return to 0: next A0/A1 pair puts A0 on port 0
      bus.a0_valid = 1'b1; bus.a0_tag = 5'd9;  bus.a0_data = 16'h9999;
      bus.a1_valid = 1'b1; bus.a1_tag = 5'd10; bus.a1_data = 16'hAAAA;
      tick();
      clear_inputs();
      expect_eq("four_c3_wb0_tag", bus.wb0_tag, 3);
      expect_eq("four_c3_wb0_data", bus.wb0_data, 16'h3333);
      expect_eq("four_c3_wb1_en", bus.wb1_en, 1);
      expect_eq("four_c3_wb1_tag", bus.wb1_tag, 4);
      expect_eq("four_c3_wb1_data", bus.wb1_data, 16'h00A5);
      tick();
      expect_eq("four_rr_wb0_tag", bus.wb0_tag, 9);
      expect_eq("four_rr_wb1_tag", bus.wb1_tag, 10);

      // tag conflict between A0 and M
      do_reset();
      bus.a0_valid = 1'b1; bus.a0_tag = 5'd7; bus.a0_data = 16'hAAAA;
      bus.m_valid  = 1'b1; bus.m_tag  = 5'd7; bus.m_data  = 16'hBBBB;
      tick();
      clear_inputs();
      tick();
      expect_eq("conf_c2_wb0_en", bus.wb0_en, 1);
      expect_eq("conf_c2_wb0_data", bus.wb0_data, 16'hAAAA);
      expect_eq("conf_c2_wb1_en", bus.wb1_en, 0);
      tick();
      expect_eq("conf_c3_wb0_en", bus.wb0_en, 1);
      expect_eq("conf_c3_wb0_tag", bus.wb0_tag, 7);
      expect_eq("conf_c3_wb0_data", bus.wb0_data, 16'hBBBB);
      expect_eq("conf_c3_wb1_en", bus.wb1_en, 0);

      // backpressure on M: A0/A1 take both ports while M fills
      do_reset();
      bus.a0_valid = 1'b1; bus.a0_tag = 5'd1; bus.a0_data = 16'h0A0A;
      bus.a1_valid = 1'b1; bus.a1_tag = 5'd2; bus.a1_data = 16'h0A1A;
      bus.m_valid  = 1'b1; bus.m_tag  = 5'd3; bus.m_data  = 16'h3001;
      tick();
      clear_inputs();
      bus.m_valid = 1'b1; bus.m_tag = 5'd3; bus.m_data = 16'h3002;
      expect_eq("bp_c1_src_ready", bus.src_ready, 4'hF);
      tick();
      bus.m_data = 16'hDEAD;
      expect_eq("bp_c2_src_ready", bus.src_ready, 4'b1011);
      expect_eq("bp_c2_overflow", bus.overflow_err, 0);
      expect_eq("bp_c2_wb0_tag", bus.wb0_tag, 1);
      expect_eq("bp_c2_wb1_tag", bus.wb1_tag, 2);
      tick();
      clear_inputs();
      expect_eq("bp_c3_overflow", bus.overflow_err, 1);
      expect_eq("bp_c3_wb0_data", bus.wb0_data, 16'h3001);
      expect_eq("bp_c3_wb1_en", bus.wb1_en, 0);
      tick();
      expect_eq("bp_c4_wb0_en", bus.wb0_en, 1);
      expect_eq("bp_c4_wb0_data", bus.wb0_data, 16'h3002);
      tick();
      expect_eq("bp_c5_wb0_en", bus.wb0_en, 0);
      expect_eq("bp_c5_wb1_en", bus.wb1_en, 0);
      expect_eq("bp_c5_overflow_sticky", bus.overflow_err, 1);
      expect_eq("bp_c5_src_ready", bus.src_ready, 4'hF);

      // fill everything, then reset mid-operation
      do_reset();
      push_all(5'd1, 16'h0101, 5'd2, 16'h0202, 5'd3, 16'h0303, 5'd4, 8'h44);
      tick();
      tick();
      tick();
      clear_inputs();
      expect_eq("mid_pre_overflow", bus.overflow_err, 1);
      rst_n = 1'b0;
      tick();
      expect_eq("mid_rst_wb0_en", bus.wb0_en, 0);
      expect_eq("mid_rst_wb1_en", bus.wb1_en, 0);
      expect_eq("mid_rst_wb0_data", bus.wb0_data, 0);
      expect_eq("mid_rst_overflow", bus.overflow_err, 0);
      expect_eq("mid_rst_src_ready", bus.src_ready, 4'hF);
      rst_n = 1'b1;
      tick();
      expect_eq("mid_post_wb0_en", bus.wb0_en, 0);
      expect_eq("mid_post_wb1_en", bus.wb1_en, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
